// File: rtl/logic_sel_pkg.sv
// Shared opcode definitions for the switch-driven logic-function selector.
package logic_sel_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_NOT  = 3'd0;
  localparam opcode_t OP_BUF  = 3'd1;
  localparam opcode_t OP_XNOR = 3'd2;
  localparam opcode_t OP_XOR  = 3'd3;
  localparam opcode_t OP_OR   = 3'd4;
  localparam opcode_t OP_NOR  = 3'd5;
  localparam opcode_t OP_AND  = 3'd6;
  localparam opcode_t OP_NAND = 3'd7;

endpackage

// File: rtl/logic_sel_unit_if.sv
// Operand/select/result bundle between switch inputs and the logic selector.
interface logic_sel_unit_if
  import logic_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] sw0;
  logic [WIDTH-1:0] sw1;
  opcode_t          select;
  logic [WIDTH-1:0] out;

  modport master (output sw0, output sw1, output select, input  out);
  modport slave  (input  sw0, input  sw1, input  select, output out);

endinterface

// File: rtl/logic_sel_core.sv
// Combinational bitwise 2-input logic function chosen by a 3-bit opcode.
module logic_sel_core
  import logic_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  output logic [WIDTH-1:0] result_c
);

  always_comb begin
    result_c = ~a;
    case (op)
      OP_NOT:  result_c = ~a;
      OP_BUF:  result_c = a;
      OP_XNOR: result_c = ~(a ^ b);
      OP_XOR:  result_c = a ^ b;
      OP_OR:   result_c = a | b;
      OP_NOR:  result_c = ~(a | b);
      OP_AND:  result_c = a & b;
      OP_NAND: result_c = ~(a & b);
      default: result_c = ~a;
    endcase
  end

endmodule

// File: rtl/logic_sel_unit.sv
// Logic-function selector with registered result; define LOGIC_SEL_UNIT_INPUT_SYNC_EN
// to add 2-flop synchronizers on sw0, sw1 and select (latency 3 instead of 1).
module logic_sel_unit
  import logic_sel_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  logic_sel_unit_if.slave  bus
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  opcode_t          op;
  logic [WIDTH-1:0] result_c;
  logic [WIDTH-1:0] out_q;

`ifdef LOGIC_SEL_UNIT_INPUT_SYNC_EN
  logic [WIDTH-1:0] sw0_s1, sw0_s2;
  logic [WIDTH-1:0] sw1_s1, sw1_s2;
  opcode_t          sel_s1, sel_s2;

  // Switches are asynchronous to clk; two flops per bit before use.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw0_s1 <= '0;
      sw0_s2 <= '0;
      sw1_s1 <= '0;
      sw1_s2 <= '0;
      sel_s1 <= '0;
      sel_s2 <= '0;
    end else begin
      sw0_s1 <= bus.sw0;
      sw0_s2 <= sw0_s1;
      sw1_s1 <= bus.sw1;
      sw1_s2 <= sw1_s1;
      sel_s1 <= bus.select;
      sel_s2 <= sel_s1;
    end
  end

  assign a  = sw0_s2;
  assign b  = sw1_s2;
  assign op = sel_s2;
`else
  assign a  = bus.sw0;
  assign b  = bus.sw1;
  assign op = bus.select;
`endif

  logic_sel_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .result_c (result_c)
  );

  // Result register; reset wins over any computed value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= result_c;
    end
  end

  assign bus.out = out_q;

endmodule

// File: tb/tb_logic_sel_unit.sv
// Directed, table-driven bench for logic_sel_unit (1-bit and 4-bit instances).
module tb_logic_sel_unit;
  import logic_sel_pkg::*;

`ifdef LOGIC_SEL_UNIT_INPUT_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  typedef struct {
    opcode_t    sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic_sel_unit_if #(.WIDTH(1)) b1 ();
  logic_sel_unit_if #(.WIDTH(4)) b4 ();

  logic_sel_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  logic_sel_unit #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive1(input opcode_t s, input logic a, input logic b);
    b1.select = s;
    b1.sw0    = a;
    b1.sw1    = b;
  endtask

  vec_t tab1[$];
  vec_t tab4[$];
  // Truth tables for codes 010..111 over (sw0,sw1) = 00,01,11,10, MSB first.
  logic [3:0] tt [8];
  logic [1:0] sweep [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive1(OP_NAND, 1'b1, 1'b1);
    b4.select = OP_NOT;
    b4.sw0    = 4'b0000;
    b4.sw1    = 4'b0000;

    tab1.push_back('{OP_NOT, 4'd0, 4'd0, 4'd1});
    tab1.push_back('{OP_NOT, 4'd0, 4'd1, 4'd1});
    tab1.push_back('{OP_NOT, 4'd1, 4'd0, 4'd0});
    tab1.push_back('{OP_NOT, 4'd1, 4'd1, 4'd0});
    tab1.push_back('{OP_BUF, 4'd0, 4'd1, 4'd0});
    tab1.push_back('{OP_BUF, 4'd0, 4'd0, 4'd0});
    tab1.push_back('{OP_BUF, 4'd1, 4'd1, 4'd1});
    tab1.push_back('{OP_BUF, 4'd1, 4'd0, 4'd1});
    tt[2] = 4'b1010;
    tt[3] = 4'b0101;
    tt[4] = 4'b0111;
    tt[5] = 4'b1000;
    tt[6] = 4'b0010;
    tt[7] = 4'b1101;
    sweep[0] = 2'b00;
    sweep[1] = 2'b01;
    sweep[2] = 2'b11;
    sweep[3] = 2'b10;
    for (int op = 2; op < 8; op++) begin
      for (int k = 0; k < 4; k++) begin
        logic [1:0] p;
        logic [3:0] t;
        p = sweep[k];
        t = tt[op];
        tab1.push_back('{3'(op), 4'(p[1]), 4'(p[0]), 4'(t[3-k])});
      end
    end

    tab4.push_back('{OP_NOT,  4'b1100, 4'b1010, 4'b0011});
    tab4.push_back('{OP_BUF,  4'b1100, 4'b1010, 4'b1100});
    tab4.push_back('{OP_XNOR, 4'b1100, 4'b1010, 4'b1001});
    tab4.push_back('{OP_XOR,  4'b1100, 4'b1010, 4'b0110});
    tab4.push_back('{OP_OR,   4'b1100, 4'b1010, 4'b1110});
    tab4.push_back('{OP_NOR,  4'b1100, 4'b1010, 4'b0001});
    tab4.push_back('{OP_AND,  4'b1100, 4'b1010, 4'b1000});
    tab4.push_back('{OP_NAND, 4'b1100, 4'b1010, 4'b0111});

    // Reset held two cycles with NAND(1,1) on the inputs.
    step(2);
    check("reset_out1", 4'(b1.out), 4'd0);
    check("reset_out4", b4.out, 4'd0);
    rst = 1'b0;
    step(LAT);
    check("release_nand11", 4'(b1.out), 4'd0);

    foreach (tab1[i]) begin
      drive1(tab1[i].sel, tab1[i].a[0], tab1[i].b[0]);
      step(LAT);
      check($sformatf("w1_op%0d_a%0d_b%0d", tab1[i].sel, tab1[i].a[0], tab1[i].b[0]),
            4'(b1.out), tab1[i].exp);
    end

    foreach (tab4[i]) begin
      b4.select = tab4[i].sel;
      b4.sw0    = tab4[i].a;
      b4.sw1    = tab4[i].b;
      step(LAT);
      check($sformatf("w4_op%0d", tab4[i].sel), b4.out, tab4[i].exp);
    end

    // Latency: OR -> AND with sw0=1, sw1=0.
    drive1(OP_OR, 1'b1, 1'b0);
    step(LAT + 1);
    check("lat_or_settled", 4'(b1.out), 4'd1);
    b1.select = OP_AND;
    #3;
    check("lat_before_edge", 4'(b1.out), 4'd1);
    step(0);
    for (int unsigned k = 1; k < LAT; k++) begin
      step(1);
      check($sformatf("lat_hold_%0d", k), 4'(b1.out), 4'd1);
    end
    step(1);
    check("lat_and_result", 4'(b1.out), 4'd0);

    // One-cycle reset during XOR(1,0).
    drive1(OP_XOR, 1'b1, 1'b0);
    step(LAT + 1);
    check("midrst_before", 4'(b1.out), 4'd1);
    rst = 1'b1;
    step(1);
    check("midrst_during", 4'(b1.out), 4'd0);
    rst = 1'b0;
    step(LAT);
    check("midrst_after", 4'(b1.out), 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
